// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO: shift-add multiply, restoring divide.
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV; without it they behave as MULTU/DIVU.
module mdu_iterative #(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem, b;
  logic                is_div, dz;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] p_fix;
  logic [DATA_W-1:0]   q_fix, r_fix;

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;
  // op[0]=0 selects the signed variants (MULT, DIV)
  assign a_neg = ~op[0] & rs[DATA_W-1];
  assign b_neg = ~op[0] & rt[DATA_W-1];
  assign a_mag = a_neg ? -rs : rs;
  assign b_mag = b_neg ? -rt : rt;
  assign p_fix = neg_q ? -prod : prod;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
`else
  assign a_mag = rs;
  assign b_mag = rt;
  assign p_fix = prod;
  assign q_fix = quo;
  assign r_fix = rem;
`endif

  // Multiply step: add multiplicand into the upper half, then shift the pair right.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, b} : '0);

  // Divide step: trial subtract on the (DATA_W+1)-bit shifted partial remainder.
  logic [DATA_W:0]   div_sh;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;
  assign div_sh   = {rem, quo[DATA_W-1]};
  assign div_ge   = div_sh >= {1'b0, b};
  assign div_diff = div_sh[DATA_W-1:0] - b;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      prod        <= '0;
      quo         <= '0;
      rem         <= '0;
      b           <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MDU_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              prod   <= {{DATA_W{1'b0}}, a_mag};
              quo    <= a_mag;
              rem    <= '0;
              b      <= b_mag;
              is_div <= op[1];
              dz     <= op[1] && (rt == '0);
`ifdef MDU_SIGNED_EN
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
`endif
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
            3'b100:  hi <= rs;
            3'b101:  lo <= rs;
            default: ;
          endcase
        end
        CALC: begin
          if (is_div) begin
            rem <= div_ge ? div_diff : div_sh[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], div_ge};
          end else begin
            prod <= {mul_sum, prod[DATA_W-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero: remainder path already yields the original rs.
          hi          <= is_div ? r_fix : p_fix[2*DATA_W-1:DATA_W];
          lo          <= is_div ? (dz ? '1 : q_fix) : p_fix[DATA_W-1:0];
          done        <= 1'b1;
          div_by_zero <= dz;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized self-checking bench for mdu_iterative against an arithmetic reference model.
module tb_mdu_iterative;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'b000;
  logic [W-1:0] rs    = '0;
  logic [W-1:0] rt    = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int ntests = 0;
  int nfail  = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mdu_iterative #(.DATA_W(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sd, p;
    logic [63:0] up;
    bit sgn;
    sgn = 0;
`ifdef MDU_SIGNED_EN
    sgn = (o == 3'b000) || (o == 3'b010);
`endif
    z  = 0;
    sa = longint'($signed(a));
    sd = longint'($signed(d));
    if (o[1] == 1'b0) begin
      if (sgn) begin p = sa * sd; up = p; end
      else up = {32'b0, a} * {32'b0, d};
      h = up[63:32];
      l = up[31:0];
    end else if (d == 0) begin
      z = 1; l = 32'hFFFF_FFFF; h = a;
    end else if (sgn) begin
      p = sa / sd; l = p[31:0];
      p = sa % sd; h = p[31:0];
    end else begin
      l = a / d; h = a % d;
    end
  endfunction

  // Issues one arithmetic op, then follows it to completion. Returns in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input bit inj, input string tag);
    logic [31:0] eh, el;
    logic ez;
    int n;
    bit busy_ok, hold_ok;
    model(o, a, d, eh, el, ez);
    @(negedge clock);
    start = 1'b1; op = o; rs = a; rt = d;
    @(posedge clock); #1;
    start = 1'b0; rs = $urandom; rt = $urandom; op = 3'($urandom);
    chk({tag, "_accept"}, {62'b0, done, busy}, 64'h1);
    n = 0; busy_ok = 1; hold_ok = 1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 0;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 0;
      if (inj && n == 5) begin start = 1'b1; op = 3'b101; rs = 32'hDEAD_BEEF; end
      else start = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_hilo_held"}, hold_ok, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_dz"}, div_by_zero, ez);
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v, input string tag);
    @(negedge clock);
    start = 1'b1; op = o; rs = v;
    @(posedge clock); #1;
    start = 1'b0;
    if (o == 3'b100) exp_hi = v;
    else if (o == 3'b101) exp_lo = v;
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_busy_done"}, {62'b0, busy, done}, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rd;
    bit seen;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    @(posedge clock); #1;

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_minint");
    run_op(3'b011, 32'd100, 32'd0, 0, "divu_zero");
    run_op(3'b010, 32'hFFFF_FF00, 32'd0, 0, "div_zero_neg");
    @(posedge clock); #1;
    mt(3'b100, 32'h1234_5678, "mthi");
    mt(3'b101, 32'h0BAD_F00D, "mtlo");
    mt(3'b110, 32'h5555_5555, "noop6");
    mt(3'b111, 32'hAAAA_AAAA, "noop7");
    run_op(3'b001, 32'h0001_2345, 32'h0000_0789, 1, "multu_inj");
    run_op(3'b001, 32'd6, 32'd7, 0, "multu_b2b");

    // Abort a divide with reset partway through.
    @(negedge clock);
    start = 1'b1; op = 3'b011; rs = 32'd1000; rt = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    run_op(3'b011, 32'd1000, 32'd3, 0, "divu_fresh");

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 5))
        0: rd = 32'd0;
        1: rd = 32'($urandom_range(1, 20));
        2: ra = 32'h8000_0000;
        3: rd = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ro, ra, rd, 0, "rand");
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in data width.
- Replaces the single-cycle combinational mult/div path in the execute stage.
- Execute issues an op with a start pulse; the unit runs iteratively (shift-add multiply, restoring divide) and reports completion.
- MFHI/MFLO read the hi/lo outputs directly; decode stalls the pipeline on busy.

Parameters:
- DATA_W, 32, operand width; hi/lo are DATA_W each; product is 2*DATA_W.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  op request, sampled only while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- rs  in  DATA_W  multiplicand / dividend / MTHI-MTLO source.
- rt  in  DATA_W  multiplier / divisor.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had rt=0.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0; FSM goes to IDLE. Reset mid-operation aborts it: no done, hi/lo cleared.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU} (accepting edge E0):
  - Latch operand magnitudes (signed ops only; see Optional Feature) and the result-sign flags.
  - Counter=0, busy=1, next state CALC.
- IDLE, start=1, op=MTHI/MTLO: hi/lo <= rs at E0; busy stays 0; no done pulse.
- IDLE, start=1, op=110/111: ignored.
- CALC: one radix-2 step per edge, edges E1..E(DATA_W); counter increments each step; leaves for FIX when counter reaches DATA_W-1 on that edge.
  - Multiply: 2*DATA_W unsigned accumulate.
  - Divide: restoring; remainder DATA_W+1 bits.
- FIX, edge E(DATA_W+1):
  - Apply sign correction; write hi=product[2W-1:W] or remainder, lo=product[W-1:0] or quotient.
  - done=1 and busy=0 for exactly one cycle; next state IDLE.
- Fixed latency: done is high in the cycle after E(DATA_W+1), i.e. 33 edges after acceptance at DATA_W=32, for every op including divide-by-zero.
- A start seen in the done cycle is accepted (back-to-back issue, no bubble).
- start while busy=1 (any op, including MTHI/MTLO): ignored, no queueing.
- rs/rt changing after E0: no effect.
- hi/lo keep their old values until the FIX edge.
- Divide by zero (rt=0): lo=all ones, hi=rs (original signed value); div_by_zero=1 with done.
- Signed division rules:
  - Quotient sign = sign(rs) XOR sign(rt); remainder takes the sign of rs.
  - MIN_INT / -1: lo=MIN_INT (wraps), hi=0; no flag.
- Signed multiply: 2*DATA_W result negated when exactly one operand is negative.

Optional Feature:
- Macro MDU_SIGNED_EN.
- Defined: MULT/DIV perform signed magnitude conversion at E0 and sign fixup in FIX.
- Undefined: MULT and DIV behave exactly as MULTU and DIVU. No magnitude or negation logic is synthesised; FIX only writes results, and latency is unchanged.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done 33 edges after E0; hi=0xFFFFFFFE lo=0x00000001; busy high throughout.
- MULT rs=0xFFFFFFFD (-3) rt=5, MDU_SIGNED_EN defined -> hi=0xFFFFFFFF lo=0xFFFFFFF1. Without the macro -> hi=0x00000004 lo=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0, div_by_zero=0.
- DIVU rs=100 rt=0 -> done at same latency; div_by_zero=1; lo=0xFFFFFFFF hi=0x00000064.
- MTHI rs=0x12345678 from idle -> hi updated next edge, no done. MTLO issued mid-MULTU -> ignored, MULTU result intact. MULTU 6*7 started in the done cycle -> lo=42 after 33 more edges.
- Reset asserted 10 edges into DIVU 1000/3 -> next cycle busy=0, hi=lo=0, no done. Fresh DIVU 1000/3 -> lo=333 hi=1.
